// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and constants for the MIPS register file
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;
  localparam int PCNT_W = 2;

  localparam logic [DATA_W-1:0] ZERO_WORD    = '0;
  localparam logic [ADDR_W-1:0] NOP_REG_ADDR = '0;
  localparam logic [PCNT_W-1:0] PCNT_MAX     = '1;
  localparam logic [PCNT_W-1:0] PCNT_ONE     = PCNT_W'(1);

  // True when a live write-back targets a non-zero register at this address.
  function automatic logic wb_hit(input logic we, input logic [ADDR_W-1:0] waddr,
                                  input logic [ADDR_W-1:0] addr);
    return we && (waddr == addr) && (addr != NOP_REG_ADDR);
  endfunction
endpackage

// File: rtl/regfile_if.sv
// rtl/regfile_if.sv - write-back, issue and operand-read bus of the register file
interface regfile_if;
  import regfile_pkg::*;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              busy1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic              busy2;
  logic              iss;
  logic [ADDR_W-1:0] iss_addr;
  logic              flush;
  logic              pend_ovf;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2, iss, iss_addr, flush,
    input  rdata1, busy1, rdata2, busy2, pend_ovf
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2, iss, iss_addr, flush,
    output rdata1, busy1, rdata2, busy2, pend_ovf
  );
endinterface

// File: rtl/regfile_pend_ctr.sv
// rtl/regfile_pend_ctr.sv - saturating pending-write counter for one register
module regfile_pend_ctr
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  input  logic              clr,
  output logic [PCNT_W-1:0] cnt
);
  logic [PCNT_W-1:0] cnt_q, cnt_d;

  // Issue and retire in the same cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !dec && cnt_q != PCNT_MAX)
      cnt_d = cnt_q + 1'b1;
    else if (dec && !inc && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 register file with write bypass and per-register pending scoreboard
module regfile
  import regfile_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  regfile_if.slave bus
);
  logic [DATA_W-1:0]            regs_q [NREG];
  logic [DATA_W-1:0]            regs_d [NREG];
  logic [NREG-1:0][PCNT_W-1:0]  pcnt;
  logic                         pend_ovf_q, pend_ovf_d;
  logic                         ovf_evt;

  always_comb begin
    regs_d = regs_q;
    if (bus.we && bus.waddr != NOP_REG_ADDR)
      regs_d[bus.waddr] = bus.wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= ZERO_WORD;
      pend_ovf_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      pend_ovf_q <= pend_ovf_d;
    end
  end

  assign pcnt[0] = '0;
  for (genvar a = 1; a < NREG; a++) begin : g_ctr
    regfile_pend_ctr u_ctr (
      .clk (clk),
      .rst (rst),
      .inc (bus.iss && bus.iss_addr == ADDR_W'(a)),
      .dec (bus.we && bus.waddr == ADDR_W'(a)),
      .clr (bus.flush),
      .cnt (pcnt[a])
    );
  end

  // A dropped issue: saturated counter, not cancelled by a same-cycle retire, not squashed.
  assign ovf_evt    = bus.iss && bus.iss_addr != NOP_REG_ADDR && !bus.flush &&
                      !wb_hit(bus.we, bus.waddr, bus.iss_addr) &&
                      pcnt[bus.iss_addr] == PCNT_MAX;
  assign pend_ovf_d = pend_ovf_q | ovf_evt;
  assign bus.pend_ovf = pend_ovf_q;

  function automatic logic [DATA_W-1:0] read_port(input logic re, input logic [ADDR_W-1:0] ra);
    if (rst || !re || ra == NOP_REG_ADDR) return ZERO_WORD;
    if (wb_hit(bus.we, bus.waddr, ra))    return bus.wdata;
    return regs_q[ra];
  endfunction

  // The write-back retiring the last outstanding write releases the operand this cycle.
  function automatic logic busy_port(input logic re, input logic [ADDR_W-1:0] ra);
    if (rst || !re || ra == NOP_REG_ADDR || pcnt[ra] == '0) return 1'b0;
    return !(wb_hit(bus.we, bus.waddr, ra) && pcnt[ra] == PCNT_ONE);
  endfunction

  assign bus.rdata1 = read_port(bus.re1, bus.raddr1);
  assign bus.rdata2 = read_port(bus.re2, bus.raddr2);
  assign bus.busy1  = busy_port(bus.re1, bus.raddr1);
  assign bus.busy2  = busy_port(bus.re2, bus.raddr2);
endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - directed self-checking bench for regfile
module tb_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  regfile_if bus ();
  regfile dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.we = 0; bus.waddr = 0; bus.wdata = 0;
    bus.re1 = 0; bus.raddr1 = 0; bus.re2 = 0; bus.raddr2 = 0;
    bus.iss = 0; bus.iss_addr = 0; bus.flush = 0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (bus.rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata1 got %h exp 0", bus.rdata1); end
    n_checks++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1 got %b exp 0", bus.busy1); end
    n_checks++; if (bus.pend_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", bus.pend_ovf); end
    step(); rst = 0;
    step(); bus.we = 1; bus.waddr = 3; bus.wdata = 32'hAA;
    step(); bus.we = 0; bus.iss = 1; bus.iss_addr = 3;
    step(); bus.iss = 0; bus.re1 = 1; bus.raddr1 = 3; #1;
    n_checks++; if (bus.rdata1 !== 32'hAA) begin n_fail++; $display("FAIL pre_rst_rdata got %h exp aa", bus.rdata1); end
    n_checks++; if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL pre_rst_busy got %b exp 1", bus.busy1); end
    #1 rst = 1; #1;
    n_checks++; if (bus.rdata1 !== 32'h0) begin n_fail++; $display("FAIL async_rst_rdata got %h exp 0", bus.rdata1); end
    n_checks++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy got %b exp 0", bus.busy1); end
    step(); rst = 0; #1;
    n_checks++; if (bus.rdata1 !== 32'h0) begin n_fail++; $display("FAIL post_rst_rdata got %h exp 0", bus.rdata1); end
    n_checks++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy got %b exp 0", bus.busy1); end
  endtask

  task automatic test_bypass();
    step(); bus.we = 1; bus.waddr = 5; bus.wdata = 32'h1234_5678; bus.re1 = 1; bus.raddr1 = 5; #1;
    n_checks++; if (bus.rdata1 !== 32'h1234_5678) begin n_fail++; $display("FAIL bypass got %h exp 12345678", bus.rdata1); end
    step(); bus.we = 0; #1;
    n_checks++; if (bus.rdata1 !== 32'h1234_5678) begin n_fail++; $display("FAIL stored got %h exp 12345678", bus.rdata1); end
    step(); bus.we = 1; bus.waddr = 0; bus.wdata = 32'hFFFF_FFFF; bus.raddr1 = 0; #1;
    n_checks++; if (bus.rdata1 !== 32'h0) begin n_fail++; $display("FAIL r0_bypass got %h exp 0", bus.rdata1); end
    step(); bus.we = 0; #1;
    n_checks++; if (bus.rdata1 !== 32'h0) begin n_fail++; $display("FAIL r0_stored got %h exp 0", bus.rdata1); end
  endtask

  task automatic test_pending();
    step(); bus.iss = 1; bus.iss_addr = 8; bus.re1 = 1; bus.raddr1 = 8; #1;
    n_checks++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL iss_same_cycle got %b exp 0", bus.busy1); end
    step(); #1;
    n_checks++; if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL pend_cnt1 got %b exp 1", bus.busy1); end
    step(); bus.iss = 0; #1;
    n_checks++; if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL pend_cnt2 got %b exp 1", bus.busy1); end
    step(); bus.we = 1; bus.waddr = 8; bus.wdata = 32'h11; #1;
    n_checks++; if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL first_wb_busy got %b exp 1", bus.busy1); end
    step(); bus.wdata = 32'h22; #1;
    n_checks++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL last_wb_busy got %b exp 0", bus.busy1); end
    n_checks++; if (bus.rdata1 !== 32'h22) begin n_fail++; $display("FAIL last_wb_data got %h exp 22", bus.rdata1); end
    step(); bus.we = 0; #1;
    n_checks++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL retired_busy got %b exp 0", bus.busy1); end
  endtask

  task automatic test_overflow();
    bus.raddr1 = 9;
    step(); bus.iss = 1; bus.iss_addr = 9;
    step(); step(); step(); #1;
    n_checks++; if (bus.pend_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b exp 0", bus.pend_ovf); end
    step(); bus.iss = 0; #1;
    n_checks++; if (bus.pend_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", bus.pend_ovf); end
    n_checks++; if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL ovf_busy got %b exp 1", bus.busy1); end
    step(); bus.we = 1; bus.waddr = 9; bus.wdata = 32'h1; #1;
    n_checks++; if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL sat_wb1 got %b exp 1", bus.busy1); end
    step(); bus.wdata = 32'h2; #1;
    n_checks++; if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL sat_wb2 got %b exp 1", bus.busy1); end
    step(); bus.wdata = 32'h3; #1;
    n_checks++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL sat_wb3 got %b exp 0", bus.busy1); end
    step(); bus.we = 0; #1;
    n_checks++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL sat_done got %b exp 0", bus.busy1); end
    n_checks++; if (bus.pend_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", bus.pend_ovf); end
  endtask

  task automatic test_iss_we_flush();
    bus.raddr1 = 10;
    step(); bus.iss = 1; bus.iss_addr = 10;
    step(); bus.iss = 0; #1;
    n_checks++; if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL r10_pend got %b exp 1", bus.busy1); end
    step(); bus.iss = 1; bus.we = 1; bus.waddr = 10; bus.wdata = 32'h5; #1;
    n_checks++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL iss_we_busy got %b exp 0", bus.busy1); end
    n_checks++; if (bus.rdata1 !== 32'h5) begin n_fail++; $display("FAIL iss_we_data got %h exp 5", bus.rdata1); end
    step(); bus.iss = 0; bus.we = 0; #1;
    n_checks++; if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL iss_we_hold got %b exp 1", bus.busy1); end
    step(); bus.flush = 1; bus.iss = 1; bus.iss_addr = 11; bus.we = 1; bus.waddr = 12; bus.wdata = 32'h77;
    bus.re2 = 1; bus.raddr2 = 11; #1;
    n_checks++; if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL flush_same_cycle got %b exp 1", bus.busy1); end
    step(); bus.flush = 0; bus.iss = 0; bus.we = 0; #1;
    n_checks++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL flush_r10 got %b exp 0", bus.busy1); end
    n_checks++; if (bus.busy2 !== 1'b0) begin n_fail++; $display("FAIL flush_r11 got %b exp 0", bus.busy2); end
    step(); bus.raddr2 = 12; #1;
    n_checks++; if (bus.rdata2 !== 32'h77) begin n_fail++; $display("FAIL flush_write got %h exp 77", bus.rdata2); end
    bus.raddr2 = 11; #1;
    n_checks++; if (bus.busy2 !== 1'b0) begin n_fail++; $display("FAIL flush_r11_later got %b exp 0", bus.busy2); end
  endtask

  task automatic test_read_enable();
    step(); bus.iss = 1; bus.iss_addr = 5;
    step(); bus.iss = 0; bus.re1 = 0; bus.raddr1 = 5; bus.re2 = 1; bus.raddr2 = 5; #1;
    n_checks++; if (bus.rdata1 !== 32'h0) begin n_fail++; $display("FAIL re_off_data got %h exp 0", bus.rdata1); end
    n_checks++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL re_off_busy got %b exp 0", bus.busy1); end
    n_checks++; if (bus.busy2 !== 1'b1) begin n_fail++; $display("FAIL port2_busy got %b exp 1", bus.busy2); end
    bus.re1 = 1; #1;
    n_checks++; if (bus.rdata1 !== 32'h1234_5678) begin n_fail++; $display("FAIL dual_p1 got %h exp 12345678", bus.rdata1); end
    n_checks++; if (bus.rdata2 !== 32'h1234_5678) begin n_fail++; $display("FAIL dual_p2 got %h exp 12345678", bus.rdata2); end
    n_checks++; if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL dual_busy1 got %b exp 1", bus.busy1); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_bypass();
    test_pending();
    test_overflow();
    test_iss_we_flush();
    test_read_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
